// File: rtl/multicycle_controller.sv
// RV32I multi-cycle control sequencer (FETCH/DECODE/EXECUTE/MEM/WRITEBACK); memory stalls on mem_ready.
// `define CTRL_TRAP_EN to trap illegal opcodes into a sticky TRAP state instead of retiring them as NOPs.
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [6:0]          i_opcode,
    input  logic [2:0]          i_funct3,
    input  logic                i_zero,
    input  logic                i_mem_ready,
    output logic                o_mem_req,
    output logic                o_mem_sel,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_ir_write,
    output logic                o_pc_write,
    output logic                o_pc_src,
    output logic                o_alu_src,
    output logic [1:0]          o_alu_op,
    output logic                o_reg_write,
    output logic                o_mem_to_reg,
    output logic [RETIRE_W-1:0] o_retired,
    output logic                o_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
`ifdef CTRL_TRAP_EN
    localparam logic [2:0] S_TRAP    = 3'd5;
`endif

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic [2:0]          r_state;
    logic [6:0]          r_opcode;
    logic                r_br_ne;
    logic [RETIRE_W-1:0] r_retired;

    logic [2:0] w_next;
    logic       w_retire;
    logic       w_dec_legal;
    logic       w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch;
    logic       w_mem_req, w_mem_sel, w_mem_read, w_mem_write;
    logic       w_ir_write, w_pc_write, w_pc_src, w_alu_src;
    logic [1:0] w_alu_op;
    logic       w_reg_write, w_mem_to_reg, w_illegal;

    // Legality is judged on the live IR in DECODE; later states only see latched copies.
    assign w_dec_legal = (i_opcode == OP_R) || (i_opcode == OP_I) ||
                         (i_opcode == OP_LOAD) || (i_opcode == OP_STORE) ||
                         ((i_opcode == OP_BRANCH) && (i_funct3[2:1] == 2'b00));

    assign w_is_r      = (r_opcode == OP_R);
    assign w_is_i      = (r_opcode == OP_I);
    assign w_is_load   = (r_opcode == OP_LOAD);
    assign w_is_store  = (r_opcode == OP_STORE);
    assign w_is_branch = (r_opcode == OP_BRANCH);

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (i_mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_dec_legal) begin
                    w_next = S_EXECUTE;
                end else begin
`ifdef CTRL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
`endif
                end
            end
            S_EXECUTE: begin
                if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (w_is_branch) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (i_mem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: w_next = S_TRAP;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_sel    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_ir_write = i_mem_ready;
                w_pc_write = i_mem_ready;
            end
            S_EXECUTE: begin
                if (w_is_r) begin
                    w_alu_op = 2'b10;
                end else if (w_is_i) begin
                    w_alu_src = 1'b1;
                    w_alu_op  = 2'b10;
                end else if (w_is_load || w_is_store) begin
                    w_alu_src = 1'b1;
                end else if (w_is_branch) begin
                    // BNE inverts the sense of the ALU zero flag.
                    w_alu_op   = 2'b01;
                    w_pc_write = i_zero ^ r_br_ne;
                    w_pc_src   = i_zero ^ r_br_ne;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_sel   = 1'b1;
                w_mem_read  = w_is_load;
                w_mem_write = w_is_store;
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = w_is_load;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: w_illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= 7'd0;
            r_br_ne   <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= i_opcode;
                r_br_ne  <= i_funct3[0];
            end
            if (w_retire) r_retired <= r_retired + RETIRE_ONE;
        end
    end

    // Reset gates every control combinationally so an in-flight access drops the instant reset asserts.
    assign o_mem_req    = w_mem_req    & i_rst_n;
    assign o_mem_sel    = w_mem_sel    & i_rst_n;
    assign o_mem_read   = w_mem_read   & i_rst_n;
    assign o_mem_write  = w_mem_write  & i_rst_n;
    assign o_ir_write   = w_ir_write   & i_rst_n;
    assign o_pc_write   = w_pc_write   & i_rst_n;
    assign o_pc_src     = w_pc_src     & i_rst_n;
    assign o_alu_src    = w_alu_src    & i_rst_n;
    assign o_alu_op     = w_alu_op     & {2{i_rst_n}};
    assign o_reg_write  = w_reg_write  & i_rst_n;
    assign o_mem_to_reg = w_mem_to_reg & i_rst_n;
    assign o_illegal    = w_illegal    & i_rst_n;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-instruction phase model builds the expected control vector for every cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_sel;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_sel, mem_read, mem_write, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_op;
    logic        reg_write, mem_to_reg, illegal;
    logic [31:0] retired;

    ctl_t        act;
    ctl_t        exp_ctl = '0;
    logic [31:0] exp_ret = 32'd0;
    bit          chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          ncyc;

    always #5 clk = ~clk;

    multicycle_controller #(.RETIRE_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
        .i_zero(zero), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_sel(mem_sel), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_ir_write(ir_write), .o_pc_write(pc_write),
        .o_pc_src(pc_src), .o_alu_src(alu_src), .o_alu_op(alu_op),
        .o_reg_write(reg_write), .o_mem_to_reg(mem_to_reg),
        .o_retired(retired), .o_illegal(illegal)
    );

    assign act = {mem_req, mem_sel, mem_read, mem_write, ir_write, pc_write, pc_src,
                  alu_src, alu_op, reg_write, mem_to_reg, illegal};

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (act !== exp_ctl) begin
                n_fail++;
                $display("FAIL ctl cycle %0d: got %b want %b", cyc_cnt, act, exp_ctl);
            end
            n_tests++;
            if (retired !== exp_ret) begin
                n_fail++;
                $display("FAIL retired cycle %0d: got %0d want %0d", cyc_cnt, retired, exp_ret);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One clock of the model: drive inputs, publish the expected vector, retire after the edge.
    task automatic step(input ctl_t e, input logic rdy, input bit ret);
        mem_ready = rdy;
        exp_ctl   = e;
        chk_en    = 1'b1;
        @(posedge clk);
        #1;
        if (ret) exp_ret = exp_ret + 32'd1;
        cyc_cnt++;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("reset ctl", 32'(act), 32'd0);
        chk("reset retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_ret = 32'd0;
    endtask

    // kind: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, input int rst_at, output int n);
        ctl_t c;
        int   kind;
        int   n0;
        bit   trap;
`ifdef CTRL_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        n0 = cyc_cnt;
        opcode = op; funct3 = f3; zero = z;
        case (op)
            7'b0110011: kind = 0;
            7'b0010011: kind = 1;
            7'b0000011: kind = 2;
            7'b0100011: kind = 3;
            7'b1100011: kind = (f3 == 3'd0 || f3 == 3'd1) ? 4 : 5;
            default:    kind = 5;
        endcase
        for (int w = 0; w < fw; w++) begin
            c = '0; c.mem_req = 1'b1;
            step(c, 1'b0, 1'b0);
        end
        c = '0; c.mem_req = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        step(c, 1'b1, 1'b0);
        c = '0;
        step(c, 1'b1, kind == 5 && !trap);
        if (kind == 5) begin
            if (trap) begin
                for (int t = 0; t < 4; t++) begin
                    c = '0; c.illegal = 1'b1;
                    step(c, 1'b1, 1'b0);
                end
            end
            n = cyc_cnt - n0;
            return;
        end
        c = '0;
        case (kind)
            0: c.alu_op = 2'b10;
            1: begin c.alu_src = 1'b1; c.alu_op = 2'b10; end
            2, 3: c.alu_src = 1'b1;
            default: begin
                c.alu_op   = 2'b01;
                c.pc_write = z ^ f3[0];
                c.pc_src   = z ^ f3[0];
            end
        endcase
        step(c, 1'b1, kind == 4);
        if (kind == 2 || kind == 3) begin
            c = '0; c.mem_req = 1'b1; c.mem_sel = 1'b1;
            c.mem_read = (kind == 2); c.mem_write = (kind == 3);
            for (int w = 0; w < mw; w++) begin
                if (w == rst_at) begin
                    chk_en = 1'b0;
                    mem_ready = 1'b0;
                    #2;
                    chk("mem_write before reset", 32'(mem_write), 32'd1);
                    rst_n = 1'b0;
                    #1;
                    chk("mem_req in reset", 32'(mem_req), 32'd0);
                    chk("mem_write in reset", 32'(mem_write), 32'd0);
                    chk("retired in reset", retired, 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(posedge clk);
                    #1;
                    exp_ret = 32'd0;
                    n = cyc_cnt - n0;
                    return;
                end
                step(c, 1'b0, 1'b0);
            end
            step(c, 1'b1, kind == 3);
        end
        if (kind != 3 && kind != 4) begin
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = (kind == 2);
            step(c, 1'b1, 1'b1);
        end
        n = cyc_cnt - n0;
    endtask

    initial begin
        #3;
        chk("reset ctl", 32'(act), 32'd0);
        chk("reset retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(7'b0010011, 3'd0, 1'b0, 0, 0, -1, ncyc);   // ADDI
        chk("ADDI cycles", 32'(ncyc), 32'd4);
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, -1, ncyc);   // ADD
        chk("ADD cycles", 32'(ncyc), 32'd4);
        chk("retired after 2", retired, 32'd2);

        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3, -1, ncyc);   // LW, 3 data waits
        chk("LW cycles", 32'(ncyc), 32'd8);
        run_instr(7'b1100011, 3'd0, 1'b1, 0, 0, -1, ncyc);   // BEQ taken
        chk("BEQ cycles", 32'(ncyc), 32'd3);
        run_instr(7'b1100011, 3'd1, 1'b1, 0, 0, -1, ncyc);   // BNE not taken
        chk("BNE cycles", 32'(ncyc), 32'd3);
        run_instr(7'b1100011, 3'd1, 1'b0, 0, 0, -1, ncyc);   // BNE taken
        run_instr(7'b0100011, 3'd2, 1'b0, 2, 1, -1, ncyc);   // SW, fetch and data waits
        chk("SW cycles", 32'(ncyc), 32'd7);
        chk("retired after 7", retired, 32'd7);

        run_instr(7'b0000000, 3'd0, 1'b0, 0, 0, -1, ncyc);   // illegal
`ifdef CTRL_TRAP_EN
        chk("illegal sticky", 32'(illegal), 32'd1);
        chk("no retire on trap", retired, 32'd7);
        do_reset();
`else
        chk("illegal NOP cycles", 32'(ncyc), 32'd2);
        chk("retired after NOP", retired, 32'd8);
        run_instr(7'b1100011, 3'd5, 1'b0, 0, 0, -1, ncyc);   // BGE treated as illegal
        chk("BGE NOP cycles", 32'(ncyc), 32'd2);
`endif

        exp_ret = 32'hFFFF_FFFF;
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        run_instr(7'b0010011, 3'd0, 1'b0, 0, 0, -1, ncyc);
        chk("retired wrap", retired, 32'd0);

        run_instr(7'b0100011, 3'd2, 1'b0, 0, 3, 1, ncyc);    // SW with reset mid-wait
        run_instr(7'b0110011, 3'd0, 1'b0, 1, 0, -1, ncyc);
        chk("retired after reset", retired, 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
